ahb_vga_wbuf: RTL and testbench
===============================

AHB_VGA_WBUF -- requirements
Module: ahb_vga_wbuf

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entry count; SHALL be a power of 2, minimum 2.
REQ-002 HCLK  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 HRESET  in  1  reset, asynchronous, active-high.
REQ-004 HSEL, HWRITE, HREADY  in  1 each  upstream AHB slave-side controls.
REQ-005 HTRANS  in  2  upstream transfer type.
REQ-006 HADDR, HWDATA  in  32 each  upstream address and write data.
REQ-007 HRDATA  out  32  status read data.
REQ-008 HREADYOUT  out  1  upstream stall; low only while a write data phase cannot be accepted.
REQ-009 M_HSEL, M_HWRITE  out  1 each  downstream select and write to the VGA peripheral.
REQ-010 M_HTRANS  out  2  downstream transfer type.
REQ-011 M_HADDR, M_HWDATA  out  32 each  downstream address and data.
REQ-012 M_HREADYOUT  in  1  downstream ready, i.e. the VGA peripheral's HREADYOUT (low while scrolling).
REQ-013 M_HREADY  out  1  downstream HREADY; SHALL equal M_HREADYOUT combinationally.

Function
REQ-014 Upstream address phase SHALL be captured when HREADY & HSEL & HTRANS[1]; HADDR and HWRITE SHALL be registered.
REQ-015 In a write data phase with FIFO not full: push {HADDR, HWDATA[7:0]}; HREADYOUT=1.
REQ-016 In a write data phase with FIFO full: HREADYOUT=0, no push; push SHALL occur in the first cycle FIFO is not full.
REQ-017 Read data phase: HRDATA = {26'b0, full, empty, count[3:0]}, zero-padded for the configured DEPTH; HREADYOUT=1; otherwise HRDATA=0.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; a push while full SHALL be impossible per REQ-016.
REQ-019 Pointers SHALL wrap modulo DEPTH; count SHALL be $clog2(DEPTH)+1 bits and range 0..DEPTH.
REQ-020 Downstream FSM SHALL have states IDLE, ADDR, DATA.
REQ-021 IDLE: M_HTRANS=2'b00, M_HSEL=0, M_HWRITE=0; goes to ADDR when FIFO not empty.
REQ-022 ADDR: M_HSEL=1, M_HWRITE=1, M_HTRANS=2'b10, M_HADDR=head.addr; goes to DATA when M_HREADYOUT=1, else holds with outputs stable.
REQ-023 DATA: M_HTRANS=2'b00, M_HWDATA={24'b0, head.data}; when M_HREADYOUT=1, pop head, then go to ADDR if count>1, else IDLE.
REQ-024 Minimum drain throughput SHALL be one write per 2 cycles; ordering SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-025 M_HADDR and M_HWDATA SHALL be 0 in states where they are not defined above.
REQ-026 Upstream write-to-downstream-address-phase latency SHALL be 2 cycles from an empty FIFO: push edge, then IDLE->ADDR edge.

Reset
REQ-027 Asserting HRESET SHALL asynchronously clear pointers, count and captured phase registers, and force the FSM to IDLE.
REQ-028 During reset, all outputs SHALL be 0 except HREADYOUT=1; M_HREADY SHALL follow M_HREADYOUT.
REQ-029 Reset mid-transfer SHALL discard all buffered entries; after release, no downstream transfer SHALL occur until a new push.

Structure
REQ-030 Package ahb_vga_pkg SHALL hold the HTRANS encodings, the FSM state enum and the wbuf_entry_t struct {addr[31:0], data[7:0]}.
REQ-031 Storage SHALL be a sub-module wbuf_fifo (DEPTH, entry-wide, push/pop/full/empty/count); the FSM and AHB logic stay in ahb_vga_wbuf.

Verification
REQ-032 Single write 0x00000000/0x41, M_HREADYOUT=1 -> ADDR 2 cycles later with M_HADDR=0, then DATA with M_HWDATA=0x41, FIFO empty.
REQ-033 8 back-to-back writes with M_HREADYOUT=0 -> all accepted, count=8 and full; 9th write holds HREADYOUT=0 until M_HREADYOUT rises and the first pop occurs.
REQ-034 M_HREADYOUT low 50 cycles while in ADDR -> M_HADDR and M_HTRANS stable throughout; DATA entered the cycle after it rises.
REQ-035 Writes 0x10..0x17 to address 0x00000A04, free-running drain -> downstream order 0x10..0x17, one write per 2 cycles.
REQ-036 Status read after 3 writes with drain stalled -> HRDATA=0x00000003; after full drain -> 0x00000010.
REQ-037 HRESET pulsed with 5 entries buffered and FSM in DATA -> outputs 0, FSM IDLE, no downstream transfer after release.

Source files
------------

// File: rtl/ahb_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_vga_pkg
// Purpose  : Shared types for the AHB VGA write buffer: HTRANS encodings,
//            downstream FSM state enum and the buffered entry struct.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_vga_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } wbuf_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wbuf_entry_t;

    // NONSEQ and SEQ start a real transfer; IDLE and BUSY do not.
    // Equivalent to testing HTRANS[1].
    function automatic logic htrans_active(input logic [1:0] t);
        logic act;
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wbuf_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wbuf_fifo
// Purpose  : Synchronous FIFO of wbuf_entry_t words, DEPTH entries.
// Ports    : clk, rst (async, active-high)
//            i_push/i_data  - write an entry (ignored when full)
//            i_pop          - drop the head entry (ignored when empty)
//            o_head         - current head entry (valid when !o_empty)
//            o_full/o_empty - occupancy flags
//            o_count        - occupancy 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module wbuf_fifo
    import ahb_vga_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  wbuf_entry_t              i_data,
    input  logic                     i_pop,
    output wbuf_entry_t              o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    assign do_push = i_push & ~o_full;
    assign do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/ahb_vga_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : ahb_vga_wbuf
// Purpose  : Posted-write buffer between an AHB master and the VGA
//            peripheral. Upstream writes are queued and acknowledged
//            immediately unless the queue is full; a small FSM replays them
//            downstream in strict order, absorbing VGA scroll stalls.
// Ports    : HCLK/HRESET          - clock, async active-high reset
//            HSEL..HWDATA         - upstream AHB slave inputs
//            HRDATA/HREADYOUT     - upstream status read data and stall
//            M_HSEL..M_HWDATA     - downstream AHB master outputs
//            M_HREADYOUT/M_HREADY - downstream ready in, and its copy out
// Revision : 1.0 - initial release
// ============================================================================
module ahb_vga_wbuf
    import ahb_vga_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        M_HSEL,
    output logic        M_HWRITE,
    output logic [1:0]  M_HTRANS,
    output logic [31:0] M_HADDR,
    output logic [31:0] M_HWDATA,
    input  logic        M_HREADYOUT,
    output logic        M_HREADY
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Status count field is at least 4 bits so small DEPTHs keep the
    // full/empty flags at bits 5/4.
    localparam int SW = (CW < 4) ? 4 : CW;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("ahb_vga_wbuf: DEPTH must be a power of 2 and at least 2");
    end

    logic          dphase_q, dphase_d;
    logic          dwrite_q, dwrite_d;
    logic [31:0]   daddr_q,  daddr_d;
    wbuf_state_e   state_q,  state_d;

    logic          wr_phase;
    logic          rd_phase;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    wbuf_entry_t   fifo_head;
    wbuf_entry_t   fifo_wdata;
    logic [SW+1:0] status;
    logic          unused_hwdata;

    // Only the low byte reaches the VGA character store.
    assign unused_hwdata = ^HWDATA[31:8];

    // ---------------- upstream address/data phase tracking -----------------
    always_comb begin
        dphase_d = dphase_q;
        dwrite_d = dwrite_q;
        daddr_d  = daddr_q;
        if (HREADY) begin
            dphase_d = HSEL & htrans_active(HTRANS);
            if (HSEL & htrans_active(HTRANS)) begin
                dwrite_d = HWRITE;
                daddr_d  = HADDR;
            end
        end
    end

    assign wr_phase   = dphase_q &  dwrite_q;
    assign rd_phase   = dphase_q & ~dwrite_q;
    // A write stalled on full is pushed the first cycle a slot frees up,
    // never in the same cycle as the pop that frees it.
    assign fifo_push  = wr_phase & ~fifo_full;
    assign HREADYOUT  = ~(wr_phase & fifo_full);
    assign fifo_wdata = '{addr: daddr_q, data: HWDATA[7:0]};

    assign status = {fifo_full, fifo_empty, SW'(fifo_count)};
    assign HRDATA = rd_phase ? 32'(status) : 32'h0;

    assign M_HREADY = M_HREADYOUT;

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (HCLK),
        .rst     (HRESET),
        .i_push  (fifo_push),
        .i_data  (fifo_wdata),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // ---------------- downstream replay FSM ---------------------------------
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        M_HSEL   = 1'b0;
        M_HWRITE = 1'b0;
        M_HTRANS = HTRANS_IDLE;
        M_HADDR  = 32'h0;
        M_HWDATA = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                M_HSEL   = 1'b1;
                M_HWRITE = 1'b1;
                M_HTRANS = HTRANS_NONSEQ;
                M_HADDR  = fifo_head.addr;
                if (M_HREADYOUT) state_d = ST_DATA;
            end
            ST_DATA: begin
                M_HWDATA = {24'h0, fifo_head.data};
                if (M_HREADYOUT) begin
                    fifo_pop = 1'b1;
                    state_d  = (fifo_count > CW'(1)) ? ST_ADDR : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dphase_q <= 1'b0;
            dwrite_q <= 1'b0;
            daddr_q  <= 32'h0;
            state_q  <= ST_IDLE;
        end else begin
            dphase_q <= dphase_d;
            dwrite_q <= dwrite_d;
            daddr_q  <= daddr_d;
            state_q  <= state_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_vga_wbuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_vga_wbuf
// Purpose  : Self-checking bench for ahb_vga_wbuf. A queue-based model of
//            the buffered writes predicts stalls, status reads, downstream
//            order, latency and drain rate; stimulus mixes directed
//            scenarios with randomised traffic and downstream stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_vga_wbuf;

    localparam int DEPTH = 8;

    logic        hclk = 1'b0;
    logic        hreset = 1'b0;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic        hready;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        m_hsel;
    logic        m_hwrite;
    logic [1:0]  m_htrans;
    logic [31:0] m_haddr;
    logic [31:0] m_hwdata;
    logic        m_hreadyout = 1'b0;
    logic        m_hready;

    // Single-slave bus: the bus HREADY is this slave's HREADYOUT.
    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb_vga_wbuf #(
        .DEPTH (DEPTH)
    ) dut (
        .HCLK        (hclk),
        .HRESET      (hreset),
        .HSEL        (hsel),
        .HWRITE      (hwrite),
        .HREADY      (hready),
        .HTRANS      (htrans),
        .HADDR       (haddr),
        .HWDATA      (hwdata),
        .HRDATA      (hrdata),
        .HREADYOUT   (hreadyout),
        .M_HSEL      (m_hsel),
        .M_HWRITE    (m_hwrite),
        .M_HTRANS    (m_htrans),
        .M_HADDR     (m_haddr),
        .M_HWDATA    (m_hwdata),
        .M_HREADYOUT (m_hreadyout),
        .M_HREADY    (m_hready)
    );

    // kind: 0 idle, 1 write, 2 status read
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } ent_t;

    op_t  ops_q[$];
    ent_t exp_q[$];
    op_t  ap;
    op_t  dp;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          mode = 1;   // 0 stall, 1 ready, 2 random, 3 one-cycle pulse
    bit          m_dphase = 1'b0;
    logic [31:0] m_dp_addr = 32'h0;
    bit          lat_armed = 1'b0;
    int          lat_push = 0;
    bit          tp_armed = 1'b0;
    int          tp_due = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic op_t idle_op();
        op_t o;
        o.kind = 0;
        o.addr = 32'h0;
        o.data = 32'h0;
        return o;
    endfunction

    function automatic logic [31:0] exp_status(input int n);
        logic [3:0] c;
        c = 4'(n);
        return {26'h0, (n == DEPTH), (n == 0), c};
    endfunction

    task automatic add_wr(input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.kind = 1;
        o.addr = a;
        o.data = d;
        ops_q.push_back(o);
    endtask

    task automatic add_rd();
        op_t o;
        o.kind = 2;
        o.addr = 32'h0;
        o.data = 32'h0;
        ops_q.push_back(o);
    endtask

    task automatic drive();
        if (ap.kind == 0) begin
            if ($urandom_range(0, 1) == 1) begin
                hsel   = 1'b1;
                htrans = 2'b00;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b10;
            end
            hwrite = 1'($urandom_range(0, 1));
            haddr  = $urandom;
        end else begin
            hsel   = 1'b1;
            htrans = 2'b10;
            hwrite = (ap.kind == 1);
            haddr  = ap.addr;
        end
        hwdata = (dp.kind == 1) ? dp.data : $urandom;
        case (mode)
            0: m_hreadyout = 1'b0;
            1: m_hreadyout = 1'b1;
            3: begin
                m_hreadyout = 1'b1;
                mode = 0;
            end
            default: m_hreadyout = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step();
        int          sz;
        bit          push;
        bit          pop;
        logic        m_addr_now;
        logic        hr;
        logic        mr;
        logic [31:0] addr_seen;
        ent_t        e;

        @(negedge hclk);
        sz  = exp_q.size();
        hr  = hreadyout;
        mr  = m_hreadyout;
        pop = 1'b0;

        check_eq("hreadyout", hreadyout, (dp.kind == 1 && sz == DEPTH) ? 1'b0 : 1'b1);
        check_eq("hrdata", hrdata, (dp.kind == 2) ? exp_status(sz) : 32'h0);
        check_eq("m_hready", m_hready, mr);
        push = (dp.kind == 1) && (sz < DEPTH);

        m_addr_now = m_hsel && (m_htrans == 2'b10);
        addr_seen  = m_haddr;
        if (sz == 0) begin
            check_eq("m_idle_hsel", m_hsel, 1'b0);
            check_eq("m_idle_htrans", m_htrans, 2'b00);
        end
        if (m_dphase && sz != 0) begin
            check_eq("m_hwdata", m_hwdata, {24'h0, exp_q[0].data});
            check_eq("m_dphase_addr", m_dp_addr, exp_q[0].addr);
            check_eq("m_dphase_htrans", m_htrans, 2'b00);
            check_eq("m_dphase_haddr0", m_haddr, 32'h0);
            pop = mr;
        end else if (m_addr_now && sz != 0) begin
            check_eq("m_haddr", m_haddr, exp_q[0].addr);
            check_eq("m_hwrite", m_hwrite, 1'b1);
            check_eq("m_addr_hwdata0", m_hwdata, 32'h0);
        end else begin
            check_eq("m_idle_haddr0", m_haddr, 32'h0);
            check_eq("m_idle_hwdata0", m_hwdata, 32'h0);
        end

        if (lat_armed) begin
            check_eq("wr_to_addr_latency", m_addr_now, (cyc == lat_push + 1));
            if (cyc >= lat_push + 1) lat_armed = 1'b0;
        end

        // A pop with more entries queued must be followed by the next pop
        // two edges later whenever the VGA side stays ready.
        if (tp_armed) begin
            if (cyc + 1 == tp_due - 1 && !mr) begin
                tp_armed = 1'b0;
            end else if (cyc + 1 == tp_due) begin
                if (mr) check_eq("drain_rate", pop, 1'b1);
                tp_armed = 1'b0;
            end
        end

        @(posedge hclk);
        cyc++;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() == 0) begin
                lat_armed = 1'b1;
                lat_push  = cyc;
            end
            e.addr = dp.addr;
            e.data = dp.data[7:0];
            exp_q.push_back(e);
        end
        if (pop && sz > 1) begin
            tp_armed = 1'b1;
            tp_due   = cyc + 2;
        end
        if (m_addr_now) m_dp_addr = addr_seen;
        m_dphase = (m_addr_now && mr) || (m_dphase && !mr);
        if (hr) begin
            dp = ap;
            ap = (ops_q.size() != 0) ? ops_q.pop_front() : idle_op();
        end
        #1;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(ops_q.size() == 0 && ap.kind == 0 && dp.kind == 0 &&
                 exp_q.size() == 0 && !m_dphase) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_left", 32'(exp_q.size() + ops_q.size()), 32'h0);
    endtask

    // Asserted mid-cycle so the clear is seen before the next clock edge.
    task automatic do_reset();
        #2;
        hreset      = 1'b1;
        m_hreadyout = 1'($urandom_range(0, 1));
        #1;
        check_eq("rst_hreadyout", hreadyout, 1'b1);
        check_eq("rst_hrdata", hrdata, 32'h0);
        check_eq("rst_m_hsel", m_hsel, 1'b0);
        check_eq("rst_m_hwrite", m_hwrite, 1'b0);
        check_eq("rst_m_htrans", m_htrans, 2'b00);
        check_eq("rst_m_haddr", m_haddr, 32'h0);
        check_eq("rst_m_hwdata", m_hwdata, 32'h0);
        check_eq("rst_m_hready", m_hready, m_hreadyout);
        ops_q.delete();
        exp_q.delete();
        ap        = idle_op();
        dp        = idle_op();
        m_dphase  = 1'b0;
        lat_armed = 1'b0;
        tp_armed  = 1'b0;
        hsel      = 1'b0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        haddr     = 32'h0;
        hwdata    = 32'h0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int k;
        ap = idle_op();
        dp = idle_op();
        do_reset();

        // Single write, immediate drain.
        mode = 1;
        add_wr(32'h0000_0000, 32'h0000_0041);
        drain(40);
        add_rd();
        drain(20);

        // Status after three writes with the drain stalled, then after drain.
        mode = 0;
        for (int i = 0; i < 3; i++) add_wr(32'h0000_0100 + 32'(i), 32'h20 + 32'(i));
        add_rd();
        run(12);
        mode = 1;
        drain(60);
        add_rd();
        drain(20);

        // Fill to full, read status, ninth write stalls until a pop.
        mode = 0;
        for (int i = 0; i < 8; i++) add_wr(32'h0000_2000 + 32'(4 * i), 32'h30 + 32'(i));
        add_rd();
        add_wr(32'h0000_2ff0, 32'h0000_00ee);
        run(20);
        mode = 1;
        drain(100);
        add_rd();
        drain(20);

        // Long downstream stall in the address phase.
        mode = 0;
        add_wr(32'h0000_0a00, 32'h0000_0055);
        run(50);
        mode = 1;
        drain(40);

        // Back-to-back writes to one address with free-running drain.
        mode = 1;
        for (int i = 0; i < 8; i++) add_wr(32'h0000_0a04, 32'h10 + 32'(i));
        drain(80);

        // Randomised traffic with varying downstream readiness.
        for (int b = 0; b < 15; b++) begin
            r    = $urandom_range(0, 9);
            mode = (r == 0) ? 0 : ((r < 4) ? 1 : 2);
            for (int i = 0; i < 20; i++) begin
                k = $urandom_range(0, 5);
                if (k < 3)       add_wr($urandom, $urandom);
                else if (k == 3) add_rd();
                else             ops_q.push_back(idle_op());
            end
            run(25);
        end
        mode = 2;
        drain(3000);

        // Reset while entries are buffered and the FSM is in DATA.
        mode = 0;
        for (int i = 0; i < 5; i++) add_wr(32'h0000_3000 + 32'(i), 32'h60 + 32'(i));
        run(12);
        mode = 3;
        run(3);
        check_eq("in_data_before_reset", m_dphase, 1'b1);
        do_reset();
        mode = 1;
        run(20);
        add_wr(32'h0000_4000, 32'h0000_0077);
        add_wr(32'h0000_4004, 32'h0000_0078);
        drain(40);
        add_rd();
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
